// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant bundle between eight requesters and the shared-mux arbiter.
// The master side drives requests and enable. The slave side (the arbiter) returns grant and select.
interface mux8_rr_arbiter_if;
  logic       enable;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       grant_valid;

  modport master (output enable, req, input grant, sel, grant_valid);
  modport slave  (input enable, req, output grant, sel, grant_valid);
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for a shared 8:1 mux: registered one-hot grant plus 3-bit select.
// A grant is held while its owner keeps requesting, for at most MAX_HOLD cycles.
module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mux8_rr_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state, state_nxt;
  logic [2:0] pointer, pointer_nxt;
  logic [3:0] hold_cnt, hold_nxt;
  logic [7:0] grant_nxt;
  logic [2:0] sel_nxt;
  logic       valid_nxt;

  logic [15:0] req_dbl;
  logic [7:0]  rotated;
  logic [2:0]  offset;
  logic        found;
  logic [2:0]  winner;
  logic        take_new;
  logic        go_idle;

  // Rotate requests so that the pointer position becomes bit 0, then pick the lowest set bit.
  always_comb begin
    req_dbl = {bus.req, bus.req} >> pointer;
    rotated = req_dbl[7:0];
    found   = 1'b0;
    offset  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rotated[i]) begin
        found  = 1'b1;
        offset = 3'(i);
      end
    end
    winner = pointer + offset;
  end

  always_comb begin
    state_nxt   = state;
    pointer_nxt = pointer;
    hold_nxt    = hold_cnt;
    grant_nxt   = bus.grant;
    sel_nxt     = bus.sel;
    valid_nxt   = bus.grant_valid;
    take_new    = 1'b0;
    go_idle     = 1'b0;

    case (state)
      IDLE: begin
        if (bus.enable && found) take_new = 1'b1;
        else                     go_idle  = 1'b1;
      end
      GRANT: begin
        // While in GRANT, sel is the owner's index.
        if (!bus.enable)               go_idle  = 1'b1;
        else if (!bus.req[bus.sel]) begin
          if (found) take_new = 1'b1;
          else       go_idle  = 1'b1;
        end
        else if (hold_cnt < HOLD_LAST) hold_nxt = hold_cnt + 4'd1;
        else                           take_new = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase

    if (take_new) begin
      state_nxt   = GRANT;
      grant_nxt   = 8'b1 << winner;
      sel_nxt     = winner;
      valid_nxt   = 1'b1;
      pointer_nxt = winner + 3'd1;
      hold_nxt    = 4'd0;
    end else if (go_idle) begin
      state_nxt = IDLE;
      grant_nxt = 8'd0;
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      pointer         <= 3'd0;
      hold_cnt        <= 4'd0;
      bus.grant       <= 8'd0;
      bus.sel         <= 3'd0;
      bus.grant_valid <= 1'b0;
    end else begin
      state           <= state_nxt;
      pointer         <= pointer_nxt;
      hold_cnt        <= hold_nxt;
      bus.grant       <= grant_nxt;
      bus.sel         <= sel_nxt;
      bus.grant_valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural round-robin model.
module tb_mux8_rr_arbiter;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  mux8_rr_arbiter_if bus();

  mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state: current owner (-1 when idle), search start, cycles owned so far, last select.
  int         m_owner = -1;
  int         m_ptr   = 0;
  int         m_held  = 0;
  logic [2:0] m_sel   = 3'd0;

  function automatic int rrPick(input logic [7:0] r, input int from);
    for (int d = 0; d < 8; d++) begin
      if (r[(from + d) % 8]) return (from + d) % 8;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int         w;
    int         n_owner;
    int         n_ptr;
    int         n_held;
    logic [2:0] n_sel;
    if (!rst_n) begin
      m_owner <= -1;
      m_ptr   <= 0;
      m_held  <= 0;
      m_sel   <= 3'd0;
    end else begin
      n_owner = m_owner;
      n_ptr   = m_ptr;
      n_held  = m_held;
      n_sel   = m_sel;
      if (!bus.enable) begin
        n_owner = -1;
      end else if (m_owner < 0 || !bus.req[m_owner] || m_held >= MAX_HOLD) begin
        w = rrPick(bus.req, m_ptr);
        if (w < 0) begin
          n_owner = -1;
        end else begin
          n_owner = w;
          n_ptr   = (w + 1) % 8;
          n_held  = 1;
          n_sel   = 3'(w);
        end
      end else begin
        n_held = m_held + 1;
      end
      m_owner <= n_owner;
      m_ptr   <= n_ptr;
      m_held  <= n_held;
      m_sel   <= n_sel;
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] g,
                             input logic [2:0] s, input logic v);
    total++;
    if (bus.grant !== g || bus.sel !== s || bus.grant_valid !== v) begin
      bad++;
      $display("[TB] FAIL %s @%0t: got grant=%h sel=%0d valid=%b, want grant=%h sel=%0d valid=%b",
               name, $time, bus.grant, bus.sel, bus.grant_valid, g, s, v);
    end
  endtask

  // Every falling edge, the DUT must agree with the model.
  always @(negedge clk) begin
    logic [7:0] exp_g;
    exp_g = (m_owner < 0) ? 8'd0 : (8'd1 << m_owner);
    checkOutput("model", exp_g, m_sel, m_owner >= 0);
  end

  task automatic applyStimulus(input logic [7:0] r, input logic en);
    bus.req    = r;
    bus.enable = en;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  logic [7:0] rnd_req;
  logic       rnd_en;

  initial begin
    rst_n = 1'b0;
    applyStimulus(8'hFF, 1'b1);
    #12;
    checkOutput("reset_state", 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;
    step();
    checkOutput("reset_first_grant", 8'h01, 3'd0, 1'b1);

    $display("[TB] rotation with all requesters");
    for (int c = 1; c < 36; c++) begin
      step();
      checkOutput("rotation", 8'h01 << ((c / 4) % 8), 3'((c / 4) % 8), 1'b1);
    end

    $display("[TB] early release");
    doReset();
    applyStimulus(8'h24, 1'b1);
    step();
    checkOutput("release_grant2", 8'h04, 3'd2, 1'b1);
    step();
    checkOutput("release_hold2", 8'h04, 3'd2, 1'b1);
    applyStimulus(8'h20, 1'b1);
    step();
    checkOutput("release_to5", 8'h20, 3'd5, 1'b1);

    $display("[TB] sole requester");
    doReset();
    applyStimulus(8'h10, 1'b1);
    for (int c = 0; c < 12; c++) begin
      step();
      checkOutput("sole_req", 8'h10, 3'd4, 1'b1);
    end

    $display("[TB] enable drop");
    doReset();
    applyStimulus(8'hFF, 1'b1);
    repeat (9) step();
    checkOutput("enable_pre", 8'h04, 3'd2, 1'b1);
    applyStimulus(8'h81, 1'b0);
    step();
    checkOutput("enable_drop", 8'h00, 3'd2, 1'b0);
    applyStimulus(8'h81, 1'b1);
    step();
    checkOutput("enable_resume", 8'h80, 3'd7, 1'b1);

    $display("[TB] async reset mid-grant");
    applyStimulus(8'hFF, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    checkOutput("async_restart", 8'h01, 3'd0, 1'b1);

    $display("[TB] random traffic");
    rnd_req = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       rnd_req = 8'($urandom);
          1:       rnd_req = 8'($urandom) & 8'($urandom);
          2:       rnd_req = 8'h1 << $urandom_range(0, 7);
          default: rnd_req = rnd_req & ~bus.grant;
        endcase
      end
      rnd_en = ($urandom_range(0, 15) != 0);
      applyStimulus(rnd_req, rnd_en);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 1'b0;
        #1 checkOutput("rand_async_reset", 8'h00, 3'd0, 1'b0);
        #1 rst_n = 1'b1;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
